// File: rtl/cam_stream_pkg.sv
// Shared types and helpers for the camera stream capture block.
package cam_stream_pkg;

    typedef enum logic [2:0] {
        WAIT_VS,
        WAIT_SOF,
        LINE_IDLE,
        CAPTURE,
        DROP
    } cap_state_t;

    // Per-pixel sideband stored next to the pixel data in every FIFO entry.
    typedef struct packed {
        logic sof;
        logic eol;
    } pix_tag_t;

    function automatic int pixel_width(input int din_w, input int bytes_per_pixel);
        return din_w * bytes_per_pixel;
    endfunction

endpackage

// File: rtl/cam_stream_fifo.sv
// Synchronous first-word-fall-through FIFO: the head entry is visible on rd_data
// whenever empty is low. A write into a full FIFO is accepted only alongside a read.
module cam_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is not reset; count and pointers decide what is valid, and a
    // reset-free array can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cam_stream_capture.sv
// Camera byte-bus capture to AXI4-Stream pixels (tuser = SOF, tlast = EOL), FIFO-buffered.
// Build macro CAM_STREAM_STATS_EN adds per-frame line/pixel statistics outputs.
module cam_stream_capture
    import cam_stream_pkg::*;
#(
    parameter int DIN_W           = 8,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int FIFO_DEPTH      = 16,
    parameter int CNT_W           = 12
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DIN_W-1:0]                 din,
    input  logic                             href,
    input  logic                             vsync,
    input  logic                             enable,
    input  logic                             ovf_clear,
    output logic [DIN_W*BYTES_PER_PIXEL-1:0] m_tdata,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic                             m_tuser,
    output logic                             m_tlast,
    output logic                             overflow,
    output logic                             frame_done
`ifdef CAM_STREAM_STATS_EN
    ,
    output logic [CNT_W-1:0]                 line_count,
    output logic [CNT_W-1:0]                 pixels_per_line,
    output logic                             line_len_err
`endif
);
    localparam int         PIX_W    = pixel_width(DIN_W, BYTES_PER_PIXEL);
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_PIXEL - 1);

    typedef struct packed {
        pix_tag_t         tag;
        logic [PIX_W-1:0] data;
    } fifo_entry_t;

    logic [DIN_W-1:0] d_r;
    logic             href_r, vs_r, href_q, vs_q;
    logic             vs_rise, vs_fall, href_rise;
    cap_state_t       state, state_n;
    logic             cap, line_start, line_end, fd_pulse, arm_sof;
    logic             pix_done, push_req, drop, pop;
    logic             fifo_full, fifo_empty;
    logic [1:0]       byte_idx, idx_cur;
    logic [PIX_W-1:0] asm_n, hold_data;
    logic             hold_valid, hold_sof, sof_r;
    fifo_entry_t      push_entry, head_entry;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_r    <= '0;
            href_r <= 1'b0;
            vs_r   <= 1'b0;
            href_q <= 1'b0;
            vs_q   <= 1'b0;
        end else begin
            d_r    <= din;
            href_r <= href;
            vs_r   <= vsync;
            href_q <= href_r;
            vs_q   <= vs_r;
        end
    end

    assign vs_rise   = vs_r && !vs_q;
    assign vs_fall   = !vs_r && vs_q;
    assign href_rise = href_r && !href_q;

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_VS;
        else       state <= state_n;
    end

    // NOTE: every signal gets a default first so no path through the case leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_n    = state;
        cap        = 1'b0;
        line_start = 1'b0;
        line_end   = 1'b0;
        fd_pulse   = 1'b0;
        arm_sof    = 1'b0;
        unique case (state)
            WAIT_VS: if (vs_r) state_n = WAIT_SOF;
            WAIT_SOF, DROP: begin
                if (vs_fall) begin
                    if (enable) begin
                        state_n = LINE_IDLE;
                        arm_sof = 1'b1;
                    end else begin
                        state_n = WAIT_VS;
                    end
                end
            end
            LINE_IDLE: begin
                if (vs_rise) begin
                    state_n  = WAIT_SOF;
                    fd_pulse = 1'b1;
                end else if (href_rise) begin
                    state_n    = CAPTURE;
                    line_start = 1'b1;
                    cap        = 1'b1;
                end
            end
            CAPTURE: begin
                if (vs_rise) begin
                    state_n  = WAIT_SOF;
                    fd_pulse = 1'b1;
                    line_end = 1'b1;
                end else if (!href_r) begin
                    state_n  = LINE_IDLE;
                    line_end = 1'b1;
                end else begin
                    cap = 1'b1;
                end
            end
            default: state_n = WAIT_VS;
        endcase
        // The first byte of a line arrives on the href rising cycle itself.
        idx_cur  = line_start ? 2'd0 : byte_idx;
        pix_done = cap && (idx_cur == LAST_IDX);
        push_req = hold_valid && (pix_done || line_end);
        drop     = push_req && fifo_full && !pop;
        if (drop) state_n = DROP;
    end

    generate
        if (BYTES_PER_PIXEL == 1) begin : g_single
            assign asm_n = d_r;
        end else begin : g_multi
            logic [PIX_W-DIN_W-1:0] asm_r;
            assign asm_n = {asm_r, d_r};
            always_ff @(posedge clk) begin
                if (reset)    asm_r <= '0;
                else if (cap) asm_r <= asm_n[PIX_W-DIN_W-1:0];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx   <= 2'd0;
            hold_valid <= 1'b0;
            hold_sof   <= 1'b0;
            hold_data  <= '0;
            sof_r      <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (cap) byte_idx <= pix_done ? 2'd0 : idx_cur + 2'd1;
            if (arm_sof) sof_r <= 1'b1;
            if (pix_done && !drop) begin
                hold_valid <= 1'b1;
                hold_data  <= asm_n;
                hold_sof   <= sof_r;
                sof_r      <= 1'b0;
            end else if (drop || line_end) begin
                hold_valid <= 1'b0;
            end
            frame_done <= fd_pulse && !drop;
            if (ovf_clear) overflow <= 1'b0;
            if (drop)      overflow <= 1'b1;
        end
    end

    assign push_entry = '{tag: '{sof: hold_sof, eol: line_end}, data: hold_data};

    cam_stream_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_req && !drop),
        .wr_data (push_entry),
        .rd_en   (pop),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   ()
    );

    assign m_tvalid = !fifo_empty;
    assign pop      = m_tvalid && m_tready;
    assign m_tdata  = m_tvalid ? head_entry.data : '0;
    assign m_tuser  = m_tvalid && head_entry.tag.sof;
    assign m_tlast  = m_tvalid && head_entry.tag.eol;

`ifdef CAM_STREAM_STATS_EN
    logic [CNT_W-1:0] pix_cnt, pix_base, pix_cnt_n;
    logic [CNT_W-1:0] line_cnt, line_cnt_n;
    logic [CNT_W-1:0] first_len, last_len, last_len_n;
    logic             first_seen;

    always_comb begin
        pix_base   = line_start ? '0 : pix_cnt;
        pix_cnt_n  = (pix_done && pix_base != '1) ? pix_base + CNT_W'(1) : pix_base;
        line_cnt_n = (line_end && line_cnt != '1) ? line_cnt + CNT_W'(1) : line_cnt;
        last_len_n = line_end ? pix_cnt : last_len;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt         <= '0;
            line_cnt        <= '0;
            first_len       <= '0;
            last_len        <= '0;
            first_seen      <= 1'b0;
            line_count      <= '0;
            pixels_per_line <= '0;
            line_len_err    <= 1'b0;
        end else begin
            pix_cnt  <= pix_cnt_n;
            last_len <= last_len_n;
            line_cnt <= arm_sof ? '0 : line_cnt_n;
            if (arm_sof)       first_seen <= 1'b0;
            else if (line_end) first_seen <= 1'b1;
            if (line_end && !first_seen) first_len <= pix_cnt;
            if (ovf_clear) line_len_err <= 1'b0;
            if (line_end && first_seen && pix_cnt != first_len) line_len_err <= 1'b1;
            if (fd_pulse && !drop) begin
                line_count      <= line_cnt_n;
                pixels_per_line <= last_len_n;
            end
        end
    end
`endif

endmodule
